// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Queues 5-byte command frames from the UART receive front end and runs
//   each frame as one transaction on a 16-bit req/ack register bus. After
//   each transaction it returns a status/response byte stream to the UART
//   transmitter. Only one bus transaction is outstanding at a time, and
//   frames complete strictly in order.
// Ports:
//   clk40M, reset          : clock, synchronous active-high reset
//   cmdUpdate, cmd,        : frame strobe and frame bytes
//   addrLsb/Msb, dataLsb/Msb
//   cmdDrop                : pulse, a frame was lost to a full FIFO
//   busReq/We/Addr/Wdata   : register bus request side
//   busAck, busRdata       : register bus completion side
//   txData/txValid/txReady : response byte stream (valid/ready)
//   busy                   : FIFO non-empty or transaction in flight
//   errCnt                 : saturating bus timeout count
module uart_cmd_sequencer #(
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] CMD_WR  = 8'hA0,
    parameter logic [7:0] CMD_RD  = 8'hA1,
    parameter logic [7:0] CMD_WRV = 8'hA2
) (
    input  logic        clk40M,
    input  logic        reset,
    input  logic        cmdUpdate,
    input  logic [7:0]  cmd,
    input  logic [7:0]  addrLsb,
    input  logic [7:0]  addrMsb,
    input  logic [7:0]  dataLsb,
    input  logic [7:0]  dataMsb,
    output logic        cmdDrop,
    output logic        busReq,
    output logic        busWe,
    output logic [15:0] busAddr,
    output logic [15:0] busWdata,
    input  logic        busAck,
    input  logic [15:0] busRdata,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy,
    output logic [7:0]  errCnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;
    state_t state;

    // FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [39:0]   fifoMem [DEPTH];
    logic [AW:0]   wrPtr, rdPtr;
    logic          fifoEmpty, fifoFull, cmdKnown, pop, push;
    logic [39:0]   head;

    logic [TW-1:0] tmoCnt;
    logic          oneByte;   // CMD_WR: status byte only
    logic          isWrv;     // write phase is followed by a readback
    logic [15:0]   rdata;
    logic [1:0]    byteIdx;

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign cmdKnown  = (cmd == CMD_WR) || (cmd == CMD_RD) || (cmd == CMD_WRV);
    assign pop       = (state == IDLE) && !fifoEmpty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push      = cmdUpdate && cmdKnown && (!fifoFull || pop);
    assign head      = fifoMem[rdPtr[AW-1:0]];

    always_ff @(posedge clk40M) begin
        if (push)
            fifoMem[wrPtr[AW-1:0]] <= {cmd, addrMsb, addrLsb, dataMsb, dataLsb};
    end

    always_ff @(posedge clk40M) begin
        if (reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            cmdDrop <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            cmdDrop <= cmdUpdate && cmdKnown && fifoFull && !pop;
            busy    <= !fifoEmpty || (state != IDLE);
        end
    end

    always_ff @(posedge clk40M) begin
        if (reset) begin
            state    <= IDLE;
            busReq   <= 1'b0;
            busWe    <= 1'b0;
            busAddr  <= '0;
            busWdata <= '0;
            txData   <= '0;
            txValid  <= 1'b0;
            errCnt   <= '0;
            tmoCnt   <= '0;
            oneByte  <= 1'b0;
            isWrv    <= 1'b0;
            rdata    <= '0;
            byteIdx  <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    busReq   <= 1'b1;
                    busWe    <= (head[39:32] != CMD_RD);
                    busAddr  <= head[31:16];
                    busWdata <= head[15:0];
                    oneByte  <= (head[39:32] == CMD_WR);
                    isWrv    <= (head[39:32] == CMD_WRV);
                    tmoCnt   <= '0;
                    rdata    <= '0;
                    state    <= BUS;
                end
                // busReq is always high in BUS, so busAck is only honoured here
                BUS: if (busAck) begin
                    busReq <= 1'b0;
                    tmoCnt <= '0;
                    if (busWe && isWrv) begin
                        state <= GAP;
                    end else begin
                        if (!busWe) rdata <= busRdata;
                        txData  <= 8'h55;
                        txValid <= 1'b1;
                        byteIdx <= '0;
                        state   <= RESP;
                    end
                end else if (tmoCnt == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT-th cycle without ack; readback is skipped
                    busReq  <= 1'b0;
                    rdata   <= '0;
                    txData  <= 8'hEE;
                    txValid <= 1'b1;
                    byteIdx <= '0;
                    state   <= RESP;
                    if (errCnt != 8'hFF) errCnt <= errCnt + 1'b1;
                end else begin
                    tmoCnt <= tmoCnt + 1'b1;
                end
                GAP: begin
                    busReq <= 1'b1;
                    busWe  <= 1'b0;
                    tmoCnt <= '0;
                    state  <= BUS;
                end
                RESP: if (txReady) begin
                    if (oneByte || byteIdx == 2'd2) begin
                        txValid <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        byteIdx <= byteIdx + 1'b1;
                        txData  <= (byteIdx == 2'd0) ? rdata[7:0] : rdata[15:8];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
module tb_uart_cmd_sequencer;
    logic        clk40M = 1'b0;
    logic        reset = 1'b1;
    logic        cmdUpdate = 1'b0;
    logic [7:0]  cmd = '0, addrLsb = '0, addrMsb = '0, dataLsb = '0, dataMsb = '0;
    logic        cmdDrop, busReq, busWe, busAck = 1'b0;
    logic [15:0] busAddr, busWdata, busRdata = 16'hDEAD;
    logic [7:0]  txData, errCnt;
    logic        txValid, txReady = 1'b0, busy;

    int total = 0;
    int bad = 0;

    uart_cmd_sequencer dut (
        .clk40M(clk40M), .reset(reset), .cmdUpdate(cmdUpdate), .cmd(cmd),
        .addrLsb(addrLsb), .addrMsb(addrMsb), .dataLsb(dataLsb), .dataMsb(dataMsb),
        .cmdDrop(cmdDrop), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
        .busWdata(busWdata), .busAck(busAck), .busRdata(busRdata),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .busy(busy), .errCnt(errCnt)
    );

    always #5 clk40M = ~clk40M;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr, wdata, rdata;
        int          ackDelay, stall;
        logic        expWe;
        int          expN;
        logic [7:0]  e0, e1, e2;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [15:0] a, input logic [15:0] d);
        cmd = c; addrLsb = a[7:0]; addrMsb = a[15:8]; dataLsb = d[7:0]; dataMsb = d[15:8];
        cmdUpdate = 1'b1;
        @(negedge clk40M);
        cmdUpdate = 1'b0;
    endtask

    task automatic ack(input logic [15:0] rd);
        busAck = 1'b1; busRdata = rd;
        @(negedge clk40M);
        busAck = 1'b0; busRdata = 16'hDEAD;
    endtask

    task automatic waitReq(input string nm);
        int w = 0;
        while (!busReq && w < 40) begin @(negedge clk40M); w++; end
        chk(nm, 32'(busReq), 32'd1);
    endtask

    task automatic collect(input int n, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input int stall);
        logic [7:0] exp [3];
        logic [7:0] held;
        int w;
        exp[0] = e0; exp[1] = e1; exp[2] = e2;
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (!txValid && w < 40) begin @(negedge clk40M); w++; end
            chk("txValid", 32'(txValid), 32'd1);
            if (b == 0 && stall > 0) begin
                held = txData;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk40M);
                    chk("txStable", 32'(txData), 32'(held));
                    chk("txHold", 32'(txValid), 32'd1);
                    chk("noReqInResp", 32'(busReq), 32'd0);
                end
            end
            chk("txByte", 32'(txData), 32'(exp[b]));
            txReady = 1'b1;
            @(negedge clk40M);
            txReady = 1'b0;
        end
        chk("txDone", 32'(txValid), 32'd0);
    endtask

    task automatic runVec(input vec_t v);
        sendFrame(v.cmd, v.addr, v.wdata);
        chk("lat1", 32'(busReq), 32'd0);
        @(negedge clk40M);
        chk("lat2", 32'(busReq), 32'd1);
        chk("we", 32'(busWe), 32'(v.expWe));
        chk("addr", 32'(busAddr), 32'(v.addr));
        chk("wdata", 32'(busWdata), 32'(v.wdata));
        repeat (v.ackDelay) begin
            @(negedge clk40M);
            chk("reqHold", 32'(busReq), 32'd1);
            chk("addrStable", 32'(busAddr), 32'(v.addr));
        end
        ack(v.rdata);
        chk("reqDrop", 32'(busReq), 32'd0);
        if (v.cmd == 8'hA2) begin
            @(negedge clk40M);
            chk("gapReq", 32'(busReq), 32'd1);
            chk("gapWe", 32'(busWe), 32'd0);
            chk("gapAddr", 32'(busAddr), 32'(v.addr));
            repeat (v.ackDelay) @(negedge clk40M);
            ack(v.rdata);
            chk("reqDrop2", 32'(busReq), 32'd0);
        end
        collect(v.expN, v.e0, v.e1, v.e2, v.stall);
        chk("busyLag", 32'(busy), 32'd1);
        @(negedge clk40M);
        chk("busyIdle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, drops;
        vecs[0] = '{8'hA0, 16'h1234, 16'hABCD, 16'h0000, 3, 0, 1'b1, 1, 8'h55, 8'h00, 8'h00};
        vecs[1] = '{8'hA1, 16'h0010, 16'h0000, 16'hBEEF, 1, 5, 1'b0, 3, 8'h55, 8'hEF, 8'hBE};
        vecs[2] = '{8'hA2, 16'h0020, 16'h5A5A, 16'h5A5A, 2, 0, 1'b1, 3, 8'h55, 8'h5A, 8'h5A};
        vecs[3] = '{8'hA1, 16'hFFFF, 16'h0000, 16'h0001, 0, 2, 1'b0, 3, 8'h55, 8'h01, 8'h00};

        // reset state
        repeat (2) @(negedge clk40M);
        reset = 1'b0;
        chk("rstReq", 32'(busReq), 32'd0);
        chk("rstTxValid", 32'(txValid), 32'd0);
        chk("rstBusy", 32'(busy), 32'd0);
        chk("rstErr", 32'(errCnt), 32'd0);
        chk("rstDrop", 32'(cmdDrop), 32'd0);
        chk("rstAddr", 32'(busAddr), 32'd0);

        for (int i = 0; i < 4; i++) runVec(vecs[i]);

        // read timeout: busReq high for exactly TIMEOUT cycles
        sendFrame(8'hA1, 16'h0040, 16'h0000);
        waitReq("tmoReq");
        n = 0;
        while (busReq && n < 400) begin n++; @(negedge clk40M); end
        chk("tmoCycles", 32'(n), 32'd255);
        collect(3, 8'hEE, 8'h00, 8'h00, 0);
        chk("errCnt1", 32'(errCnt), 32'd1);

        // ack in the very cycle the timeout would fire: ack wins
        sendFrame(8'hA1, 16'h0041, 16'h0000);
        waitReq("tmoAckReq");
        n = 1;
        while (n < 255) begin @(negedge clk40M); n++; end
        chk("tmoAckStillReq", 32'(busReq), 32'd1);
        ack(16'h1357);
        chk("tmoAckDrop", 32'(busReq), 32'd0);
        collect(3, 8'h55, 8'h57, 8'h13, 0);
        chk("errCntHeld", 32'(errCnt), 32'd1);
        @(negedge clk40M);

        // overflow: 6 back-to-back writes with ack withheld
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            cmd = 8'hA0; addrLsb = 8'(i); addrMsb = 8'h01; dataLsb = 8'(i); dataMsb = 8'h00;
            cmdUpdate = 1'b1;
            @(negedge clk40M);
            if (cmdDrop) drops++;
            if (i == 5) chk("dropAt6", 32'(cmdDrop), 32'd1);
        end
        cmd = 8'h77;
        @(negedge clk40M);
        cmdUpdate = 1'b0;
        if (cmdDrop) drops++;
        repeat (3) begin @(negedge clk40M); if (cmdDrop) drops++; end
        chk("dropCount", 32'(drops), 32'd1);
        for (int k = 0; k < 5; k++) begin
            waitReq("ovfReq");
            chk("ovfAddr", 32'(busAddr), 32'(16'h0100 + 16'(k)));
            chk("ovfWe", 32'(busWe), 32'd1);
            chk("ovfWdata", 32'(busWdata), 32'(k));
            ack(16'h0000);
            collect(1, 8'h55, 8'h00, 8'h00, 0);
        end
        n = 0;
        repeat (5) begin @(negedge clk40M); if (busReq) n++; end
        chk("ovfNoExtra", 32'(n), 32'd0);
        chk("ovfBusy", 32'(busy), 32'd0);

        // reset mid-read with another frame queued
        sendFrame(8'hA1, 16'h0200, 16'h0000);
        waitReq("rstMidReq");
        sendFrame(8'hA0, 16'h0300, 16'h1111);
        reset = 1'b1;
        @(negedge clk40M);
        reset = 1'b0;
        chk("midRstReq", 32'(busReq), 32'd0);
        chk("midRstTx", 32'(txValid), 32'd0);
        chk("midRstErr", 32'(errCnt), 32'd0);
        n = 0;
        repeat (20) begin
            ack(16'hAAAA);
            if (busReq || txValid) n++;
        end
        chk("midRstQuiet", 32'(n), 32'd0);
        chk("midRstBusy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
